// File: rtl/data_mem_if.sv
// Data-memory request/response bus between the processor and a memory responder.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder with programmable wait states.
// One request in flight: accept, count down WAIT cycles, access the array,
// then hold the response until the processor takes it.
module data_mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH];
  logic        mem_we;

  logic             acc_err;
  logic [IDX_W-1:0] idx;

  // Misaligned or beyond the array: the access is refused and memory untouched.
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
  assign idx     = addr_q[IDX_W+1:2];

  // Next-state and response computation for the request FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = WAIT_CNT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          if (acc_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (we_q) begin
            mem_we      = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            rsp_rdata_d = mem_q[idx];
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready is registered off the next state, so it only rises after a handshake.
    req_ready_d = (state_d == S_IDLE);
  end

  // Control, latched request and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Backing word array; cleared on reset, written at the store access edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with WAIT=2 and one
// with WAIT=0, both DEPTH=64, sharing a clock.
module tb_data_mem_responder;

  logic clk;
  logic rst_na;
  logic rst_nb;

  int checks;
  int failures;

  data_mem_if bus_a ();
  data_mem_if bus_b ();

  data_mem_responder #(.DEPTH(64), .WAIT(2)) dut_a (
    .clk   (clk),
    .reset (rst_na),
    .bus   (bus_a)
  );

  data_mem_responder #(.DEPTH(64), .WAIT(0)) dut_b (
    .clk   (clk),
    .reset (rst_nb),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Full transaction on instance A; inputs change at negedge, outputs sampled there.
  task automatic do_req_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
    int cyc;
    bus_a.req_valid = 1'b1;
    bus_a.req_we    = we;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wd;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    check("a_rdy_busy", {31'd0, bus_a.req_ready}, 32'd0);
    cyc = 0;
    while (bus_a.rsp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("a_latency", cyc, 32'd3);
    rd  = bus_a.rsp_rdata;
    err = bus_a.rsp_err;
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
    check("a_vld_clr", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("a_rd_clr", bus_a.rsp_rdata, 32'd0);
    check("a_rdy_back", {31'd0, bus_a.req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        err;
  int          cyc;

  // B timeline after the first accept edge: (ready, valid, rdata)
  logic        b_rdy [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        b_vld [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] b_rd  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0055, 32'h0};

  initial begin
    checks   = 0;
    failures = 0;
    rst_na = 1'b0;
    rst_nb = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0;   bus_a.rsp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0;   bus_b.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_rdy", {31'd0, bus_a.req_ready}, 32'd1);
    check("rst_vld", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("rst_rd", bus_a.rsp_rdata, 32'd0);
    check("rst_err", {31'd0, bus_a.rsp_err}, 32'd0);
    rst_na = 1'b1;
    rst_nb = 1'b1;
    @(negedge clk);

    // 1: store then load
    do_req_a(1'b1, 32'h10, 32'hDEAD_BEEF, rd, err);
    check("t1_st_rd", rd, 32'd0);
    check("t1_st_err", {31'd0, err}, 32'd0);
    do_req_a(1'b0, 32'h10, 32'h0, rd, err);
    check("t1_ld_rd", rd, 32'hDEAD_BEEF);
    check("t1_ld_err", {31'd0, err}, 32'd0);

    // 2: misaligned accesses
    do_req_a(1'b0, 32'h12, 32'h0, rd, err);
    check("t2_ld12_err", {31'd0, err}, 32'd1);
    check("t2_ld12_rd", rd, 32'd0);
    do_req_a(1'b1, 32'h13, 32'h1234_5678, rd, err);
    check("t2_st13_err", {31'd0, err}, 32'd1);
    do_req_a(1'b0, 32'h10, 32'h0, rd, err);
    check("t2_ld10_rd", rd, 32'hDEAD_BEEF);

    // 3: range boundary
    do_req_a(1'b1, 32'h100, 32'hAAAA_5555, rd, err);
    check("t3_st100_err", {31'd0, err}, 32'd1);
    do_req_a(1'b0, 32'hFC, 32'h0, rd, err);
    check("t3_ldfc_err", {31'd0, err}, 32'd0);
    check("t3_ldfc_rd", rd, 32'd0);
    do_req_a(1'b1, 32'hFC, 32'h0BAD_F00D, rd, err);
    do_req_a(1'b0, 32'hFC, 32'h0, rd, err);
    check("t3_ldfc2_rd", rd, 32'h0BAD_F00D);
    do_req_a(1'b0, 32'h0, 32'h0, rd, err);
    check("t3_ld0_rd", rd, 32'd0);

    // 4: back-pressure in RESP, with a competing request that must be ignored
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 32'h10;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    cyc = 0;
    while (bus_a.rsp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_latency", cyc, 32'd3);
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_wdata = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_vld", {31'd0, bus_a.rsp_valid}, 32'd1);
      check("t4_hold_rd", bus_a.rsp_rdata, 32'hDEAD_BEEF);
      check("t4_hold_rdy", {31'd0, bus_a.req_ready}, 32'd0);
    end
    bus_a.req_valid = 1'b0;
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    bus_a.rsp_ready = 1'b0;
    check("t4_rel_vld", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("t4_rel_rdy", {31'd0, bus_a.req_ready}, 32'd1);
    do_req_a(1'b0, 32'h10, 32'h0, rd, err);
    check("t4_ld10_rd", rd, 32'hDEAD_BEEF);

    // 5: reset during WAIT of a store
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 32'h20;
    bus_a.req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    rst_na = 1'b0;
    #1;
    check("t5_rst_rdy", {31'd0, bus_a.req_ready}, 32'd1);
    check("t5_rst_vld", {31'd0, bus_a.rsp_valid}, 32'd0);
    check("t5_rst_rd", bus_a.rsp_rdata, 32'd0);
    check("t5_rst_err", {31'd0, bus_a.rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_na = 1'b1;
    repeat (4) @(negedge clk);
    do_req_a(1'b0, 32'h20, 32'h0, rd, err);
    check("t5_ld20_rd", rd, 32'd0);
    do_req_a(1'b0, 32'h10, 32'h0, rd, err);
    check("t5_ld10_rd", rd, 32'd0);

    // 6: WAIT=0 back-to-back, rsp_ready held high
    bus_b.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b1; bus_b.req_we = 1'b1; bus_b.req_addr = 32'h8;
    bus_b.req_wdata = 32'h0000_0055;
    @(negedge clk);
    bus_b.req_we = 1'b0; bus_b.req_wdata = 32'h0;
    for (int i = 0; i < 6; i++) begin
      check("t6_rdy", {31'd0, bus_b.req_ready}, {31'd0, b_rdy[i]});
      check("t6_vld", {31'd0, bus_b.rsp_valid}, {31'd0, b_vld[i]});
      check("t6_rd", bus_b.rsp_rdata, b_rd[i]);
      if (i == 3) bus_b.req_valid = 1'b0;
      @(negedge clk);
    end
    bus_b.rsp_ready = 1'b0;
    check("t6_err", {31'd0, bus_b.rsp_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
